csr_file: RTL and testbench

//  Architectural CSR register file; the responder for the CSR execute unit's read/write port.

---
 rtl/csr_file.sv | 240 ++++++++++++++++++++++++
 tb/tb_csr_file.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Architectural CSR file: registered reads, masked writes, trap/ertn updates, constant timer.
// Read latency 1 cycle, writes visible next edge; no backpressure, every request is accepted.
module csr_file #(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          TVAL_W    = 32
) (
    input  logic        Clk,
    input  logic        Rest,
    input  logic        ReadCsrAble,
    input  logic [13:0] ReadCsrAddr,
    output logic [31:0] ReadCsrDate,
    output logic        ReadCsrValid,
    input  logic        WriteCsrAble,
    input  logic [13:0] WriteCsrAddr,
    input  logic [31:0] WriteCsrDate,
    input  logic [31:0] WriteCsrMask,
    input  logic        TrapAble,
    input  logic [5:0]  TrapEcode,
    input  logic [31:0] TrapPc,
    input  logic        ErtnAble,
    input  logic [7:0]  HwIntIn,
    output logic [31:0] CrmdData,
    output logic [31:0] EraDate,
    output logic [31:0] EstatDate,
    output logic [31:0] EentryDate,
    output logic [9:0]  AsidDate,
    output logic [18:0] TlbEhiDate,
    output logic [5:0]  TlbIndex,
    output logic        IntPending
);

    localparam logic [13:0] A_CRMD    = 14'h00;
    localparam logic [13:0] A_PRMD    = 14'h01;
    localparam logic [13:0] A_ECFG    = 14'h04;
    localparam logic [13:0] A_ESTAT   = 14'h05;
    localparam logic [13:0] A_ERA     = 14'h06;
    localparam logic [13:0] A_EENTRY  = 14'h0C;
    localparam logic [13:0] A_TLBIDX  = 14'h10;
    localparam logic [13:0] A_TLBEHI  = 14'h11;
    localparam logic [13:0] A_TLBELO0 = 14'h12;
    localparam logic [13:0] A_TLBELO1 = 14'h13;
    localparam logic [13:0] A_ASID    = 14'h18;
    localparam logic [13:0] A_SAVE0   = 14'h30;
    localparam logic [13:0] A_SAVE1   = 14'h31;
    localparam logic [13:0] A_SAVE2   = 14'h32;
    localparam logic [13:0] A_SAVE3   = 14'h33;
    localparam logic [13:0] A_TID     = 14'h40;
    localparam logic [13:0] A_TCFG    = 14'h41;
    localparam logic [13:0] A_TVAL    = 14'h42;
    localparam logic [13:0] A_TICLR   = 14'h44;

    localparam logic [31:0] TCFG_WM = 32'hFFFF_FFFF >> (32 - TVAL_W);

    typedef enum logic {T_IDLE, T_RUN} tstate_t;

    logic [31:0] crmd, prmd, ecfg, estat, era, eentry;
    logic [31:0] tlbidx, tlbehi, tlbelo0, tlbelo1, asid, tid, tcfg;
    logic [31:0] save [4];
    logic [TVAL_W-1:0] tval, tval_d;
    tstate_t     tstate, tstate_d;

    logic [31:0] crmd_d, prmd_d, ecfg_d, estat_d, era_d;
    logic [31:0] wr_mask, wr_bits, tcfg_new, rd_val;
    logic        tcfg_hit, ticlr_hit, ti_set;

    function automatic logic [31:0] wmask_of(input logic [13:0] a);
        case (a)
            A_CRMD:                       return 32'h0000_01FF;
            A_PRMD:                       return 32'h0000_0007;
            A_ECFG:                       return 32'h0000_1BFF;
            A_ESTAT:                      return 32'h0000_0003;
            A_ERA:                        return 32'hFFFF_FFFF;
            A_EENTRY:                     return 32'hFFFF_FFC0;
            A_TLBIDX:                     return 32'hBF00_003F;
            A_TLBEHI:                     return 32'hFFFF_E000;
            A_TLBELO0, A_TLBELO1:         return 32'hFFFF_FF7F;
            A_ASID:                       return 32'h0000_03FF;
            A_SAVE0, A_SAVE1, A_SAVE2,
            A_SAVE3, A_TID:               return 32'hFFFF_FFFF;
            A_TCFG:                       return TCFG_WM;
            A_TICLR:                      return 32'h0000_0001;
            default:                      return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] m,
                                          input logic [31:0] bits);
        return (old & ~m) | bits;
    endfunction

    assign wr_mask   = WriteCsrMask & wmask_of(WriteCsrAddr);
    assign wr_bits   = WriteCsrDate & wr_mask;
    assign tcfg_hit  = WriteCsrAble && (WriteCsrAddr == A_TCFG);
    assign ticlr_hit = WriteCsrAble && (WriteCsrAddr == A_TICLR) && wr_bits[0];
    assign tcfg_new  = merge(tcfg, wr_mask, wr_bits);

    // Timer: a TCFG write overrides whatever the counter was about to do this cycle.
    always_comb begin
        tstate_d = tstate;
        tval_d   = tval;
        ti_set   = 1'b0;
        if (tstate == T_RUN) begin
            if (tval != '0) begin
                tval_d = tval - 1'b1;
                ti_set = (tval == TVAL_W'(1));
            end else if (tcfg[1]) begin
                tval_d = {tcfg[TVAL_W-1:2], 2'b00};
            end else begin
                tstate_d = T_IDLE;
            end
        end
        if (tcfg_hit) begin
            if (tcfg_new[0]) begin
                tstate_d = T_RUN;
                tval_d   = {tcfg_new[TVAL_W-1:2], 2'b00};
            end else begin
                tstate_d = T_IDLE;
                tval_d   = tval;
            end
        end
    end

    // CSR write first, then ertn, then trap layered on top so the higher priority wins per field.
    always_comb begin
        crmd_d  = crmd;
        prmd_d  = prmd;
        ecfg_d  = ecfg;
        estat_d = estat;
        era_d   = era;
        if (WriteCsrAble) begin
            case (WriteCsrAddr)
                A_CRMD:  crmd_d  = merge(crmd, wr_mask, wr_bits);
                A_PRMD:  prmd_d  = merge(prmd, wr_mask, wr_bits);
                A_ECFG:  ecfg_d  = merge(ecfg, wr_mask, wr_bits);
                A_ESTAT: estat_d = merge(estat, wr_mask, wr_bits);
                A_ERA:   era_d   = merge(era, wr_mask, wr_bits);
                default: ;
            endcase
        end
        estat_d[9:2] = HwIntIn;
        if (ticlr_hit) estat_d[11] = 1'b0;
        if (ti_set)    estat_d[11] = 1'b1;
        if (TrapAble) begin
            prmd_d[2:0]    = crmd[2:0];
            crmd_d[2:0]    = 3'b000;
            era_d          = TrapPc;
            estat_d[21:16] = TrapEcode;
        end else if (ErtnAble) begin
            crmd_d[2:0] = prmd[2:0];
            if (estat[21:16] == 6'h3F) begin
                crmd_d[3] = 1'b0;
                crmd_d[4] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_val = 32'h0;
        case (ReadCsrAddr)
            A_CRMD:    rd_val = crmd;
            A_PRMD:    rd_val = prmd;
            A_ECFG:    rd_val = ecfg;
            A_ESTAT:   rd_val = estat;
            A_ERA:     rd_val = era;
            A_EENTRY:  rd_val = eentry;
            A_TLBIDX:  rd_val = tlbidx;
            A_TLBEHI:  rd_val = tlbehi;
            A_TLBELO0: rd_val = tlbelo0;
            A_TLBELO1: rd_val = tlbelo1;
            A_ASID:    rd_val = asid;
            A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: rd_val = save[ReadCsrAddr[1:0]];
            A_TID:     rd_val = tid;
            A_TCFG:    rd_val = tcfg;
            A_TVAL:    rd_val = 32'(tval);
            default:   rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            crmd         <= 32'h8;
            prmd         <= '0;
            ecfg         <= '0;
            estat        <= '0;
            era          <= '0;
            tval         <= '0;
            tstate       <= T_IDLE;
            ReadCsrValid <= 1'b0;
            ReadCsrDate  <= '0;
        end else begin
            crmd         <= crmd_d;
            prmd         <= prmd_d;
            ecfg         <= ecfg_d;
            estat        <= estat_d;
            era          <= era_d;
            tval         <= tval_d;
            tstate       <= tstate_d;
            ReadCsrValid <= ReadCsrAble;
            if (ReadCsrAble) ReadCsrDate <= rd_val;
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            eentry  <= '0;
            tlbidx  <= '0;
            tlbehi  <= '0;
            tlbelo0 <= '0;
            tlbelo1 <= '0;
            asid    <= '0;
            tid     <= TID_RESET;
            tcfg    <= '0;
            for (int i = 0; i < 4; i++) save[i] <= '0;
        end else if (WriteCsrAble) begin
            case (WriteCsrAddr)
                A_EENTRY:  eentry  <= merge(eentry, wr_mask, wr_bits);
                A_TLBIDX:  tlbidx  <= merge(tlbidx, wr_mask, wr_bits);
                A_TLBEHI:  tlbehi  <= merge(tlbehi, wr_mask, wr_bits);
                A_TLBELO0: tlbelo0 <= merge(tlbelo0, wr_mask, wr_bits);
                A_TLBELO1: tlbelo1 <= merge(tlbelo1, wr_mask, wr_bits);
                A_ASID:    asid    <= merge(asid, wr_mask, wr_bits);
                A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                    save[WriteCsrAddr[1:0]] <= merge(save[WriteCsrAddr[1:0]], wr_mask, wr_bits);
                A_TID:     tid     <= merge(tid, wr_mask, wr_bits);
                A_TCFG:    tcfg    <= tcfg_new;
                default: ;
            endcase
        end
    end

    assign CrmdData   = crmd;
    assign EraDate    = era;
    assign EstatDate  = estat;
    assign EentryDate = eentry;
    assign AsidDate   = asid[9:0];
    assign TlbEhiDate = tlbehi[31:13];
    assign TlbIndex   = tlbidx[5:0];
    assign IntPending = (|(estat[12:0] & ecfg[12:0])) & crmd[2];

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: read responses checked through a scoreboard queue, side outputs checked directly.
module tb_csr_file;

    localparam logic [31:0] TID_RST = 32'hCAFE_0040;

    logic        Clk, Rest;
    logic        ReadCsrAble, ReadCsrValid;
    logic [13:0] ReadCsrAddr, WriteCsrAddr;
    logic [31:0] ReadCsrDate, WriteCsrDate, WriteCsrMask;
    logic        WriteCsrAble, TrapAble, ErtnAble, IntPending;
    logic [5:0]  TrapEcode, TlbIndex;
    logic [31:0] TrapPc, CrmdData, EraDate, EstatDate, EentryDate;
    logic [7:0]  HwIntIn;
    logic [9:0]  AsidDate;
    logic [18:0] TlbEhiDate;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    csr_file #(.TID_RESET(TID_RST), .TVAL_W(32)) dut (
        .Clk(Clk), .Rest(Rest),
        .ReadCsrAble(ReadCsrAble), .ReadCsrAddr(ReadCsrAddr),
        .ReadCsrDate(ReadCsrDate), .ReadCsrValid(ReadCsrValid),
        .WriteCsrAble(WriteCsrAble), .WriteCsrAddr(WriteCsrAddr),
        .WriteCsrDate(WriteCsrDate), .WriteCsrMask(WriteCsrMask),
        .TrapAble(TrapAble), .TrapEcode(TrapEcode), .TrapPc(TrapPc),
        .ErtnAble(ErtnAble), .HwIntIn(HwIntIn),
        .CrmdData(CrmdData), .EraDate(EraDate), .EstatDate(EstatDate),
        .EentryDate(EentryDate), .AsidDate(AsidDate), .TlbEhiDate(TlbEhiDate),
        .TlbIndex(TlbIndex), .IntPending(IntPending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rest && ReadCsrValid) begin
            if (sb_q.size() == 0) begin
                check("rd_unexpected", 32'h1, 32'h0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check(e.tag, ReadCsrDate, e.exp);
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic csr_wr(input logic [13:0] a, input logic [31:0] d,
                          input logic [31:0] m = 32'hFFFF_FFFF);
        WriteCsrAble = 1'b1; WriteCsrAddr = a; WriteCsrDate = d; WriteCsrMask = m;
        tick();
        WriteCsrAble = 1'b0; WriteCsrMask = 32'h0;
    endtask

    task automatic csr_rd(input logic [13:0] a, input logic [31:0] exp, input string tag);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        ReadCsrAble = 1'b1; ReadCsrAddr = a;
        tick();
        ReadCsrAble = 1'b0;
    endtask

    task automatic trap(input logic [5:0] ec, input logic [31:0] pc, input logic with_ertn);
        TrapAble = 1'b1; TrapEcode = ec; TrapPc = pc; ErtnAble = with_ertn;
        tick();
        TrapAble = 1'b0; ErtnAble = 1'b0;
    endtask

    task automatic ertn();
        ErtnAble = 1'b1;
        tick();
        ErtnAble = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rest = 1'b1;
        ReadCsrAble = 1'b0; ReadCsrAddr = '0;
        WriteCsrAble = 1'b0; WriteCsrAddr = '0; WriteCsrDate = '0; WriteCsrMask = '0;
        TrapAble = 1'b0; TrapEcode = '0; TrapPc = '0; ErtnAble = 1'b0; HwIntIn = '0;
        tick(2);
        check("rst_crmd", CrmdData, 32'h8);
        check("rst_estat", EstatDate, 32'h0);
        check("rst_era", EraDate, 32'h0);
        check("rst_rvalid", 32'(ReadCsrValid), 32'h0);
        check("rst_rdata", ReadCsrDate, 32'h0);
        check("rst_intp", 32'(IntPending), 32'h0);
        Rest = 1'b0;
        tick();
        csr_rd(14'h00, 32'h8, "rd_crmd_rst");
        csr_rd(14'h40, TID_RST, "rd_tid_rst");

        csr_wr(14'h30, 32'hFFFF_0000);
        csr_wr(14'h30, 32'h1234_5678, 32'h0000_FFFF);
        csr_rd(14'h30, 32'hFFFF_5678, "masked_wr");
        csr_wr(14'h7F, 32'h1234_5678);
        csr_rd(14'h7F, 32'h0, "unmapped");
        csr_wr(14'h0C, 32'hFFFF_FFFF);
        csr_rd(14'h0C, 32'hFFFF_FFC0, "eentry_ro_bits");
        check("eentry_out", EentryDate, 32'hFFFF_FFC0);
        csr_wr(14'h04, 32'hFFFF_FFFF);
        csr_rd(14'h04, 32'h0000_1BFF, "ecfg_ro_bits");
        csr_wr(14'h04, 32'h0);
        csr_wr(14'h10, 32'hFFFF_FFFF);
        check("tlbidx_out", 32'(TlbIndex), 32'h3F);
        csr_rd(14'h10, 32'hBF00_003F, "tlbidx_ro_bits");
        csr_wr(14'h00, 32'hFFFF_FFFF);
        check("crmd_ro_bits", CrmdData, 32'h1FF);

        // Read and write of ERA in the same cycle: the read sees the old value.
        WriteCsrAble = 1'b1; WriteCsrAddr = 14'h06; WriteCsrDate = 32'hA0; WriteCsrMask = 32'hFFFF_FFFF;
        csr_rd(14'h06, 32'h0, "rdw_old");
        WriteCsrAble = 1'b0; WriteCsrMask = 32'h0;
        csr_rd(14'h06, 32'hA0, "rdw_new");

        csr_wr(14'h00, 32'h7);
        trap(6'h0B, 32'h1C00_0100, 1'b0);
        check("trap_crmd", CrmdData, 32'h0);
        check("trap_era", EraDate, 32'h1C00_0100);
        check("trap_ecode", 32'(EstatDate[21:16]), 32'h0B);
        csr_rd(14'h01, 32'h7, "trap_prmd");
        ertn();
        check("ertn_crmd", CrmdData, 32'h7);

        trap(6'h3F, 32'h0, 1'b0);
        ertn();
        check("ertn_tlbr", CrmdData, 32'h17);
        trap(6'h3F, 32'h2000, 1'b1);
        check("trap_ertn_crmd", CrmdData, 32'h10);
        check("trap_ertn_era", EraDate, 32'h2000);

        csr_wr(14'h00, 32'h15);
        WriteCsrAble = 1'b1; WriteCsrAddr = 14'h00; WriteCsrDate = 32'h1FF; WriteCsrMask = 32'hFFFF_FFFF;
        trap(6'h05, 32'h3000, 1'b0);
        WriteCsrAble = 1'b0; WriteCsrMask = 32'h0;
        check("prio_crmd", CrmdData, 32'h1F8);
        csr_rd(14'h01, 32'h5, "prio_prmd");

        HwIntIn = 8'hA5;
        tick();
        check("hwint_estat", EstatDate, 32'h0005_0294);
        HwIntIn = 8'h00;
        csr_wr(14'h05, 32'hFFFF_FFFF);
        csr_rd(14'h05, 32'h0005_0003, "estat_sw_bits");
        csr_wr(14'h05, 32'h0);

        // One-shot timer: Init=2 -> TVAL 8 down to 0, TI on the 1->0 step.
        csr_wr(14'h04, 32'h800);
        csr_wr(14'h00, 32'h4);
        csr_wr(14'h41, 32'h9);
        for (int i = 0; i < 9; i++) begin
            csr_rd(14'h42, 32'(8 - i), $sformatf("oneshot_tval%0d", i));
            check($sformatf("oneshot_ti%0d", i), 32'(EstatDate[11]), (i >= 7) ? 32'h1 : 32'h0);
            check($sformatf("oneshot_intp%0d", i), 32'(IntPending), (i >= 7) ? 32'h1 : 32'h0);
        end
        tick(3);
        csr_rd(14'h42, 32'h0, "oneshot_hold0");
        csr_rd(14'h41, 32'h9, "tcfg_rd");
        csr_wr(14'h44, 32'h1);
        check("ticlr_ti", 32'(EstatDate[11]), 32'h0);
        check("ticlr_intp", 32'(IntPending), 32'h0);
        csr_rd(14'h44, 32'h0, "ticlr_rd");

        // Periodic timer: Init=1 -> 4,3,2,1,0 then reload 4.
        csr_wr(14'h41, 32'h7);
        for (int i = 0; i < 7; i++) begin
            int e;
            e = (i < 5) ? (4 - i) : (9 - i);
            csr_rd(14'h42, 32'(e), $sformatf("per_tval%0d", i));
        end
        check("per_ti", 32'(EstatDate[11]), 32'h1);
        csr_wr(14'h41, 32'h6);
        csr_rd(14'h42, 32'h2, "freeze_a");
        tick(2);
        check("rd_hold_data", ReadCsrDate, 32'h2);
        check("rd_hold_valid", 32'(ReadCsrValid), 32'h0);
        csr_rd(14'h42, 32'h2, "freeze_b");
        csr_wr(14'h44, 32'h1);

        csr_wr(14'h41, 32'h5);
        tick(3);
        csr_wr(14'h44, 32'h1);
        check("set_beats_clr", 32'(EstatDate[11]), 32'h1);
        csr_wr(14'h44, 32'h1);

        csr_rd(14'h30, 32'hFFFF_5678, "pre_rst_save0");
        csr_wr(14'h41, 32'h9);
        tick(3);
        csr_rd(14'h42, 32'h5, "pre_rst_tval");
        #2 Rest = 1'b1;
        #1;
        check("mid_rst_crmd", CrmdData, 32'h8);
        check("mid_rst_estat", EstatDate, 32'h0);
        check("mid_rst_era", EraDate, 32'h0);
        check("mid_rst_eentry", EentryDate, 32'h0);
        check("mid_rst_rdata", ReadCsrDate, 32'h0);
        check("mid_rst_rvalid", 32'(ReadCsrValid), 32'h0);
        check("mid_rst_intp", 32'(IntPending), 32'h0);
        @(negedge Clk);
        Rest = 1'b0;
        tick();
        csr_rd(14'h42, 32'h0, "post_rst_tval");
        csr_rd(14'h41, 32'h0, "post_rst_tcfg");
        tick(3);
        csr_rd(14'h42, 32'h0, "post_rst_stopped");
        csr_rd(14'h30, 32'h0, "post_rst_save0");
        csr_rd(14'h40, TID_RST, "post_rst_tid");

        tick(2);
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
